// File: rtl/datapath_memory_banked.sv
// Banked datapath data memory.
// Each bank has its own read/write decode, a memory-mapped I/O window, a
// one-entry write buffer with read-after-write forwarding, and a registered
// read path of one or two cycles. Banks share nothing except clock and reset.
module datapath_memory_banked #(
  parameter int WORD_WIDTH        = 36,
  parameter int ADDR_WIDTH        = 12,
  parameter int MEM_ADDR_WIDTH    = 10,
  parameter int MEM_DEPTH         = 1024,
  parameter int BANK_COUNT        = 2,
  parameter int WRITE_BASE_STRIDE = 1024,
  parameter int IO_PORT_COUNT     = 4,
  parameter int IO_PORT_BASE_ADDR = 1020,
  parameter int READ_LATENCY      = 1,
  // I/O vector slots per bank; one dummy slot remains when I/O is disabled so
  // the port vectors keep a legal width (those slots always read as 0).
  localparam int IO_SLOTS         = (IO_PORT_COUNT > 0) ? IO_PORT_COUNT : 1
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [BANK_COUNT*ADDR_WIDTH-1:0]       read_addr,
  input  logic [BANK_COUNT*ADDR_WIDTH-1:0]       write_addr,
  input  logic [BANK_COUNT*WORD_WIDTH-1:0]       write_data,
  input  logic [BANK_COUNT-1:0]                  write_valid,
  input  logic [BANK_COUNT-1:0]                  read_addr_is_io,
  input  logic [BANK_COUNT-1:0]                  write_addr_is_io,
  input  logic [BANK_COUNT*IO_SLOTS*WORD_WIDTH-1:0] io_read_data,
  output logic [BANK_COUNT*IO_SLOTS*WORD_WIDTH-1:0] io_write_data,
  output logic [BANK_COUNT*IO_SLOTS-1:0]         io_wren,
  output logic [BANK_COUNT*WORD_WIDTH-1:0]       read_data
);

  localparam logic [31:0] DEPTH_32   = 32'(MEM_DEPTH);
  localparam logic [31:0] IO_BASE_32 = 32'(IO_PORT_BASE_ADDR);
  localparam logic [31:0] IO_CNT_32  = 32'(IO_PORT_COUNT);
  localparam bit          IO_ENABLED = (IO_PORT_COUNT > 0);

  genvar gi;
  generate
    for (gi = 0; gi < BANK_COUNT; gi++) begin : g_bank
      // Bank k accepts writes in [k*stride, k*stride + depth); reads always start at 0.
      localparam logic [31:0] WR_BASE_32 = 32'(gi * WRITE_BASE_STRIDE);

      logic [ADDR_WIDTH-1:0]     rd_addr;
      logic [ADDR_WIDTH-1:0]     wr_addr;
      logic [WORD_WIDTH-1:0]     wr_data;
      logic [MEM_ADDR_WIDTH-1:0] rd_local;
      logic [MEM_ADDR_WIDTH-1:0] wr_local;
      logic [31:0]               rd_io_off;
      logic [31:0]               wr_io_off;
      logic                      rd_hit;
      logic                      wr_hit;
      logic                      rd_io_sel;
      logic                      wr_io_sel;
      logic [WORD_WIDTH-1:0]     io_rd_word;

      // Write buffer: holds an accepted RAM write for one cycle before commit.
      logic                      wb_valid_q, wb_valid_d;
      logic [MEM_ADDR_WIDTH-1:0] wb_addr_q,  wb_addr_d;
      logic [WORD_WIDTH-1:0]     wb_data_q,  wb_data_d;

      // First read stage: either the RAM output or a captured word (I/O, forward, or 0 on miss).
      logic                      use_ram_q, use_ram_d;
      logic [WORD_WIDTH-1:0]     hold_q,    hold_d;
      logic [WORD_WIDTH-1:0]     ram_rd_q;
      logic [WORD_WIDTH-1:0]     stage1_data;

      // I/O write registers, one per port.
      logic [IO_SLOTS-1:0]       io_wren_q,  io_wren_d;
      logic [WORD_WIDTH-1:0]     io_wdata_q [IO_SLOTS];
      logic [WORD_WIDTH-1:0]     io_wdata_d [IO_SLOTS];

      logic [WORD_WIDTH-1:0]     mem [MEM_DEPTH];

      assign rd_addr  = read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_addr  = write_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data  = write_data[gi*WORD_WIDTH +: WORD_WIDTH];
      assign rd_local = rd_addr[MEM_ADDR_WIDTH-1:0];
      assign wr_local = wr_addr[MEM_ADDR_WIDTH-1:0];

      // Address decode: range hits and I/O window selection; an is_io flag
      // outside the window is ignored and the access falls through to RAM.
      always_comb begin
        rd_hit    = (32'(rd_addr) < DEPTH_32);
        wr_hit    = write_valid[gi]
                    && (32'(wr_addr) >= WR_BASE_32)
                    && (32'(wr_addr) < WR_BASE_32 + DEPTH_32);
        rd_io_off = 32'(rd_local) - IO_BASE_32;
        wr_io_off = 32'(wr_local) - IO_BASE_32;
        rd_io_sel = IO_ENABLED && rd_hit && read_addr_is_io[gi]
                    && (32'(rd_local) >= IO_BASE_32) && (rd_io_off < IO_CNT_32);
        wr_io_sel = IO_ENABLED && wr_hit && write_addr_is_io[gi]
                    && (32'(wr_local) >= IO_BASE_32) && (wr_io_off < IO_CNT_32);
      end

      // Select the addressed external I/O read word.
      always_comb begin
        io_rd_word = '0;
        for (int p = 0; p < IO_SLOTS; p++) begin
          if (rd_io_off == 32'(p)) begin
            io_rd_word = io_read_data[(gi*IO_SLOTS + p)*WORD_WIDTH +: WORD_WIDTH];
          end
        end
      end

      // Write buffer reloads every cycle; only non-I/O accepted writes mark it valid.
      always_comb begin
        wb_valid_d = wr_hit && !wr_io_sel;
        wb_addr_d  = wr_local;
        wb_data_d  = wr_data;
      end

      // Read source: miss -> 0, I/O -> port word, buffer match -> forward, else RAM.
      always_comb begin
        use_ram_d = 1'b0;
        hold_d    = '0;
        if (rd_hit) begin
          if (rd_io_sel) begin
            hold_d = io_rd_word;
          end else if (wb_valid_q && (wb_addr_q == rd_local)) begin
            hold_d = wb_data_q;
          end else begin
            use_ram_d = 1'b1;
          end
        end
      end

      // I/O write strobes last one cycle; write data holds until the port is written again.
      always_comb begin
        for (int p = 0; p < IO_SLOTS; p++) begin
          io_wren_d[p]  = wr_io_sel && (wr_io_off == 32'(p));
          io_wdata_d[p] = io_wren_d[p] ? wr_data : io_wdata_q[p];
        end
      end

      // Control and data registers with asynchronous clear.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wb_valid_q <= 1'b0;
          wb_addr_q  <= '0;
          wb_data_q  <= '0;
          use_ram_q  <= 1'b0;
          hold_q     <= '0;
          io_wren_q  <= '0;
          for (int p = 0; p < IO_SLOTS; p++) begin
            io_wdata_q[p] <= '0;
          end
        end else begin
          wb_valid_q <= wb_valid_d;
          wb_addr_q  <= wb_addr_d;
          wb_data_q  <= wb_data_d;
          use_ram_q  <= use_ram_d;
          hold_q     <= hold_d;
          io_wren_q  <= io_wren_d;
          for (int p = 0; p < IO_SLOTS; p++) begin
            io_wdata_q[p] <= io_wdata_d[p];
          end
        end
      end

      // RAM: buffered commit plus synchronous read-before-write; contents are never cleared.
      always_ff @(posedge clock) begin
        if (wb_valid_q) begin
          mem[wb_addr_q] <= wb_data_q;
        end
        ram_rd_q <= mem[rd_local];
      end

      assign stage1_data = use_ram_q ? ram_rd_q : hold_q;
      assign io_wren[gi*IO_SLOTS +: IO_SLOTS] = io_wren_q;

      for (genvar pi = 0; pi < IO_SLOTS; pi++) begin : g_io_out
        assign io_write_data[(gi*IO_SLOTS + pi)*WORD_WIDTH +: WORD_WIDTH] = io_wdata_q[pi];
      end

      if (READ_LATENCY == 2) begin : g_lat2
        logic [WORD_WIDTH-1:0] out_q, out_d;

        // Extra output stage to relax timing into the ALU.
        always_comb begin
          out_d = stage1_data;
        end

        // Output register, cleared by reset.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            out_q <= '0;
          end else begin
            out_q <= out_d;
          end
        end

        assign read_data[gi*WORD_WIDTH +: WORD_WIDTH] = out_q;
      end else begin : g_lat1
        assign read_data[gi*WORD_WIDTH +: WORD_WIDTH] = stage1_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_datapath_memory_banked.sv
// Scoreboard bench for datapath_memory_banked: DUT A uses defaults (2 banks,
// latency 1), DUT B uses 4 banks with latency 2. Stimulus pushes expected
// values with a due cycle; a monitor compares them on the falling edge.
module tb_datapath_memory_banked;
  localparam int WW   = 36;
  localparam int AW   = 12;
  localparam int IOC  = 4;
  localparam int A_BC = 2;
  localparam int B_BC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [A_BC*AW-1:0]     a_raddr, a_waddr;
  logic [A_BC*WW-1:0]     a_wdata, a_rdata;
  logic [A_BC-1:0]        a_wv, a_rio, a_wio;
  logic [A_BC*IOC*WW-1:0] a_iord, a_iowd;
  logic [A_BC*IOC-1:0]    a_iowren;

  logic [B_BC*AW-1:0]     b_raddr, b_waddr;
  logic [B_BC*WW-1:0]     b_wdata, b_rdata;
  logic [B_BC-1:0]        b_wv, b_rio, b_wio;
  logic [B_BC*IOC*WW-1:0] b_iord, b_iowd;
  logic [B_BC*IOC-1:0]    b_iowren;

  datapath_memory_banked u_dut_a (
    .clock(clk), .reset_n(rst_n),
    .read_addr(a_raddr), .write_addr(a_waddr), .write_data(a_wdata),
    .write_valid(a_wv), .read_addr_is_io(a_rio), .write_addr_is_io(a_wio),
    .io_read_data(a_iord), .io_write_data(a_iowd), .io_wren(a_iowren),
    .read_data(a_rdata)
  );

  datapath_memory_banked #(.BANK_COUNT(B_BC), .READ_LATENCY(2)) u_dut_b (
    .clock(clk), .reset_n(rst_n),
    .read_addr(b_raddr), .write_addr(b_waddr), .write_data(b_wdata),
    .write_valid(b_wv), .read_addr_is_io(b_rio), .write_addr_is_io(b_wio),
    .io_read_data(b_iord), .io_write_data(b_iowd), .io_wren(b_iowren),
    .read_data(b_rdata)
  );

  // kind 0: read_data word of bank idx; 1: whole io_wren vector; 2: io_write_data slot idx
  typedef struct {
    int          dut;
    int          kind;
    int          idx;
    logic [63:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   edges   = 0;
  int   n_check = 0;
  int   n_pass  = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [63:0] get_actual(int dut, int kind, int idx);
    logic [63:0] r;
    r = '0;
    case (kind)
      0: r = (dut == 0) ? 64'(a_rdata[idx*WW +: WW]) : 64'(b_rdata[idx*WW +: WW]);
      1: r = (dut == 0) ? 64'(a_iowren) : 64'(b_iowren);
      default: r = (dut == 0) ? 64'(a_iowd[idx*WW +: WW]) : 64'(b_iowd[idx*WW +: WW]);
    endcase
    return r;
  endfunction

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= edges) begin
        logic [63:0] act;
        act = get_actual(sb_q[i].dut, sb_q[i].kind, sb_q[i].idx);
        n_check++;
        if (sb_q[i].due < edges) begin
          $display("FAIL %s dut%0d: check missed its cycle (due %0d, now %0d)",
                   sb_q[i].name, sb_q[i].dut, sb_q[i].due, edges);
        end else if (act === sb_q[i].exp) begin
          n_pass++;
          $display("check %s dut%0d ok value=%0h", sb_q[i].name, sb_q[i].dut, act);
        end else begin
          $display("FAIL %s dut%0d: got %0h expected %0h",
                   sb_q[i].name, sb_q[i].dut, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_val(int dut, int kind, int idx, logic [63:0] exp, int delay, string name);
    exp_t e;
    e.dut = dut; e.kind = kind; e.idx = idx; e.exp = exp;
    e.due = edges + delay; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic clear_inputs();
    a_wv = '0; a_rio = '0; a_wio = '0; a_wdata = '0; a_waddr = '0;
    b_wv = '0; b_rio = '0; b_wio = '0; b_wdata = '0; b_waddr = '0;
    // idle reads target an out-of-range address so they return 0
    for (int k = 0; k < A_BC; k++) a_raddr[k*AW +: AW] = AW'(2000);
    for (int k = 0; k < B_BC; k++) b_raddr[k*AW +: AW] = AW'(2000);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic a_write(int bank, int addr, logic [WW-1:0] data, bit io, bit valid);
    a_waddr[bank*AW +: AW] = AW'(addr);
    a_wdata[bank*WW +: WW] = data;
    a_wio[bank] = io;
    a_wv[bank]  = valid;
  endtask

  task automatic a_read(int bank, int addr, bit io);
    a_raddr[bank*AW +: AW] = AW'(addr);
    a_rio[bank] = io;
  endtask

  task automatic b_write(int bank, int addr, logic [WW-1:0] data);
    b_waddr[bank*AW +: AW] = AW'(addr);
    b_wdata[bank*WW +: WW] = data;
    b_wv[bank] = 1'b1;
  endtask

  task automatic b_read(int bank, int addr);
    b_raddr[bank*AW +: AW] = AW'(addr);
  endtask

  task automatic reset_checks(string tag);
    expect_val(0, 0, 0, 64'h0, 0, {tag, "_a_rd0"});
    expect_val(0, 0, 1, 64'h0, 0, {tag, "_a_rd1"});
    expect_val(0, 1, 0, 64'h0, 0, {tag, "_a_wren"});
    expect_val(0, 2, 2, 64'h0, 0, {tag, "_a_wdata2"});
    expect_val(1, 0, 3, 64'h0, 0, {tag, "_b_rd3"});
    expect_val(1, 1, 0, 64'h0, 0, {tag, "_b_wren"});
  endtask

  initial begin
    clear_inputs();
    b_iord = '0;
    for (int b = 0; b < A_BC; b++)
      for (int p = 0; p < IOC; p++)
        a_iord[(b*IOC + p)*WW +: WW] = WW'(36'h500 + b*16 + p);

    @(posedge clk); #1;
    reset_checks("rst");

    // c1: first accesses right after reset release
    next_cycle();
    rst_n = 1'b1;
    a_write(0, 5, 36'h123, 0, 1);
    a_write(1, 1024 + 7, 36'hABC, 0, 1);
    b_write(3, 3072 + 5, 36'h123);

    // c2
    next_cycle();
    a_write(0, 9, 36'h11, 0, 1);
    a_read(1, 7, 0);
    expect_val(0, 0, 1, 36'hABC, 1, "fwd_b1");

    // c3
    next_cycle();
    a_read(0, 5, 0);
    expect_val(0, 0, 0, 36'h123, 1, "raw_b0");
    a_read(1, 7, 0);
    expect_val(0, 0, 1, 36'hABC, 1, "ram_b1");
    a_write(1, 1024 + 20, 36'h20, 0, 1);
    b_read(3, 5);
    expect_val(1, 0, 3, 36'h0, 1, "b3_raw_early");
    expect_val(1, 0, 3, 36'h123, 2, "b3_raw");

    // c4: same-cycle write and read of addr 9
    next_cycle();
    a_write(0, 9, 36'h55, 0, 1);
    a_read(0, 9, 0);
    expect_val(0, 0, 0, 36'h11, 1, "same_cyc_old");
    b_write(3, 3072 + 7, 36'hABC);

    // c5
    next_cycle();
    a_read(0, 9, 0);
    expect_val(0, 0, 0, 36'h55, 1, "same_cyc_new");
    a_write(0, 20, 36'h21, 0, 1);
    b_read(3, 7);
    expect_val(1, 0, 3, 36'h0, 1, "b3_fwd_early");
    expect_val(1, 0, 3, 36'hABC, 2, "b3_fwd");

    // c6
    next_cycle();
    a_read(0, 9, 0);
    expect_val(0, 0, 0, 36'h55, 1, "ram_after_commit");
    a_write(0, 1022, 36'h999, 0, 1);
    a_read(1, 7, 0);
    expect_val(0, 0, 1, 36'hABC, 1, "ram_b1_again");

    // c7: I/O write to bank0 port 2
    next_cycle();
    a_write(0, 1022, 36'h3C, 1, 1);
    expect_val(0, 1, 0, 64'h04, 1, "io_wren_on");
    expect_val(0, 1, 0, 64'h00, 2, "io_wren_off");
    expect_val(0, 2, 2, 36'h3C, 1, "io_wdata");
    expect_val(0, 2, 2, 36'h3C, 3, "io_wdata_hold");
    a_read(1, 1024 + 7, 0);
    expect_val(0, 0, 1, 36'h0, 1, "rd_miss_1031");

    // c8
    next_cycle();
    a_read(0, 1022, 0);
    expect_val(0, 0, 0, 36'h999, 1, "io_ram_untouched");
    a_write(0, 3, 36'h33, 0, 1);
    a_read(1, 7, 0);
    expect_val(0, 0, 1, 36'hABC, 1, "ram_b1_third");

    // c9
    next_cycle();
    a_read(0, 1021, 1);
    expect_val(0, 0, 0, 36'h501, 1, "io_read");
    a_read(1, 2000, 0);
    expect_val(0, 0, 1, 36'h0, 1, "rd_miss_2000");

    // c10: out-of-range and annulled writes
    next_cycle();
    a_write(0, 1024 + 20, 36'hDEAD, 0, 1);
    a_write(1, 1024 + 20, 36'hBEEF, 0, 0);

    // c11
    next_cycle();
    a_read(0, 20, 0);
    expect_val(0, 0, 0, 36'h21, 1, "drop_range");
    a_read(1, 20, 0);
    expect_val(0, 0, 1, 36'h20, 1, "drop_annul");

    // c12: write then reset before its commit edge
    next_cycle();
    a_write(0, 3, 36'h77, 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    reset_checks("midrst");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    a_read(0, 3, 0);
    expect_val(0, 0, 0, 36'h33, 1, "reset_discard");

    // drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) next_cycle();
    while (sb_q.size() != 0) begin
      n_check++;
      $display("FAIL %s dut%0d: never checked, expected %0h",
               sb_q[0].name, sb_q[0].dut, sb_q[0].exp);
      void'(sb_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/datapath_memory_banked.md
Name: datapath_memory_banked

Overview:
Parametrised successor to the two-bank datapath data memory: BANK_COUNT independent data banks (A, B, C, ...), each with its own read/write address decode, memory-mapped I/O window, and registered read path.
- Writes pass through a one-entry write buffer per bank, with read-after-write forwarding, so the RAM write port sits off the ALU-to-memory critical path.
- Sits between the Address Offset Module / I/O predication stage and the ALU in the datapath.

Parameters:
WORD_WIDTH, 36, data word width
ADDR_WIDTH, 12, full read/write address width from the Address Offset Module
MEM_ADDR_WIDTH, 10, local bank address width; must be <= ADDR_WIDTH
MEM_DEPTH, 1024, words per bank; must be <= 2**MEM_ADDR_WIDTH
BANK_COUNT, 2, number of banks; 1..8
WRITE_BASE_STRIDE, 1024, write base of bank k is k*WRITE_BASE_STRIDE; all banks read from base 0
IO_PORT_COUNT, 4, I/O ports per bank; 0 disables the I/O logic
IO_PORT_BASE_ADDR, 1020, local address of I/O port 0
READ_LATENCY, 1, cycles from read address to read_data; legal values 1 or 2

Ports:
clock  in  1  clock; all registers on the rising edge
reset_n  in  1  asynchronous, active-low reset
read_addr  in  BANK_COUNT*ADDR_WIDTH  per-bank read address; bank k in slice k
write_addr  in  BANK_COUNT*ADDR_WIDTH  per-bank write address
write_data  in  BANK_COUNT*WORD_WIDTH  per-bank ALU result
write_valid  in  BANK_COUNT  per-bank write qualifier; 0 means annulled instruction
read_addr_is_io  in  BANK_COUNT  read targets the I/O window
write_addr_is_io  in  BANK_COUNT  write targets the I/O window
io_read_data  in  BANK_COUNT*IO_PORT_COUNT*WORD_WIDTH  external I/O read words
io_write_data  out  BANK_COUNT*IO_PORT_COUNT*WORD_WIDTH  registered I/O write words
io_wren  out  BANK_COUNT*IO_PORT_COUNT  one-cycle I/O write strobes
read_data  out  BANK_COUNT*WORD_WIDTH  final read word, from RAM or I/O

Behaviour:
Address decode, per bank k:
- Read hit when read_addr < MEM_DEPTH.
- Write hit when k*WRITE_BASE_STRIDE <= write_addr < k*WRITE_BASE_STRIDE+MEM_DEPTH, and write_valid=1.
- Local address = low MEM_ADDR_WIDTH bits of the address.
- I/O index = local address - IO_PORT_BASE_ADDR. It is used only when the is_io flag is set and the index is < IO_PORT_COUNT. Otherwise the is_io flag is ignored and the access goes to RAM.

Write path:
- Cycle 0: an accepted RAM write loads the bank's write buffer {valid, local addr, data}.
- Cycle 1: the buffer commits to RAM. The buffer reloads every cycle; valid=0 when no RAM write was accepted.
- I/O writes bypass the buffer and never write RAM:
  - Cycle 1: io_write_data[port] takes the cycle-0 data, and io_wren[port]=1 for exactly one cycle.
  - io_write_data holds its value until the next write to that port.
- Writes that miss the bank's range, or have write_valid=0, are dropped silently.

Read path:
- Cycle 0: address presented.
- The RAM does a synchronous read, read-before-write against the commit in progress.
- Forwarding: if the write buffer is valid and its address equals the read local address, the buffer data replaces the RAM data. This gives a write at cycle N followed by a read at N+1 the new value.
- Same-cycle write and read to the same address: the read returns the old value (the write is still in the buffer during cycle 0).
- I/O read: io_read_data[port] is sampled at the cycle-0 edge.
- A read that misses the range returns 0.
- READ_LATENCY=1: read_data is valid at cycle 1.
- READ_LATENCY=2: an extra output register makes read_data valid at cycle 2.

Banks are fully independent; there is no cross-bank forwarding.

Reset, asynchronous, while reset_n=0:
- Write buffers: valid=0.
- io_wren = 0, io_write_data = 0, read_data registers = 0.
- RAM contents are not reset.
- A write buffered when reset asserts is discarded and never reaches RAM.
- The first access is accepted on the first rising edge after reset_n deasserts.

Test Plan:
- Defaults. Write bank0 addr 5 = 0x123 at cycle N, read addr 5 at N+2 → read_data bank0 = 0x123 at N+3.
- Forwarding. Write bank1 addr 1024+7 = 0xABC at cycle N, read bank1 addr 7 at N+1 → 0xABC at N+2.
- Same-cycle. Same cycle: write addr 9 = 0x55 and read addr 9, where the old value is 0x11 → read returns 0x11; a read one cycle later returns 0x55.
- I/O write. write_addr_is_io=1, bank0 local 1022, data 0x3C → io_wren bank0 bit 2 high for exactly one cycle; io_write_data port 2 = 0x3C and held; RAM[1022] unchanged.
- Range and annul. Write addr 1024 to bank0 → dropped. Write with write_valid=0 → dropped. Read addr 2000 → 0.
- Reset mid-write. Write addr 3 = 0x77, then assert reset_n=0 before the commit edge → all outputs 0 immediately; after release, a read of addr 3 returns the prior value.
- READ_LATENCY=2, BANK_COUNT=4: repeat the first two scenarios on bank 3 → data appears one cycle later than with READ_LATENCY=1.
